// File: rtl/alu_flags_stage.sv
// Sequential add/subtract stage: A/B operand registers, full_adder ripple chain,
// registered result with carry/zero flags. Define ALU_OVERFLOW_FLAG_EN to add flag_v.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module alu_flags_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             a_load,
  input  logic             b_load,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             op_sub,
  input  logic             op_wb,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
`ifdef ALU_OVERFLOW_FLAG_EN
  output logic             flag_v,
`endif
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q;
  logic             sub_q;
  logic             wb_q;
  logic [WIDTH-1:0] result_q;
  logic             flag_c_q;
  logic             flag_z_q;

  logic [WIDTH-1:0] b_chain;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH:0]   carry;

  // Subtract is A + ~B + 1; sub_q supplies both the inversion and the carry-in.
  assign b_chain  = b_q ^ {WIDTH{sub_q}};
  assign carry[0] = sub_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a  (a_q[i]),
      .b  (b_chain[i]),
      .ci (carry[i]),
      .s  (sum_d[i]),
      .co (carry[i+1])
    );
  end

`ifdef ALU_OVERFLOW_FLAG_EN
  logic flag_v_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_v_q <= 1'b0;
    end else if (state_q == EXEC) begin
      flag_v_q <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end
  assign flag_v = flag_v_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sub_q    <= 1'b0;
      wb_q     <= 1'b0;
      result_q <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (a_load) a_q <= bus_in;
          if (b_load) b_q <= bus_in;
          if (op_valid) begin
            sub_q   <= op_sub;
            wb_q    <= op_wb;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result_q <= sum_d;
          flag_c_q <= carry[WIDTH];
          flag_z_q <= (sum_d == '0);
          if (wb_q) a_q <= sum_d;
          state_q  <= HOLD;
        end
        HOLD: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_ready  = (state_q == IDLE);
  assign res_valid = (state_q == HOLD);
  assign result    = result_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;

endmodule
